lsu_mc: RTL and testbench

//  Multi-channel header load/store unit for the free-list allocator. N_CH core channels share one

---
 rtl/lsu_mc.sv | 256 +++++++++++++++++++++++++
 tb/tb_lsu_mc.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mc.sv
`default_nettype none
// ============================================================================
// Module  : lsu_mc
// Brief   : Multi-channel free-list header load/store unit. Round-robin shared
//           memory port, lock spin+CAS with bounded retries and backoff.
// Revision: 1.0
// ============================================================================
module lsu_mc #(
   parameter int DATA_W      = 64,
   parameter int N_CH        = 2,
   parameter int NEXT_OFFSET = 8,
   parameter int LOCK_OFFSET = 16,
   parameter int MAX_TRIES   = 8,
   parameter int BACKOFF_CYC = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic [N_CH-1:0]          req_val_i,
   output logic [N_CH-1:0]          req_rdy_o,
   input  logic [3*N_CH-1:0]        req_op_i,
   input  logic [DATA_W*N_CH-1:0]   req_addr_i,
   input  logic [DATA_W*N_CH-1:0]   req_size_i,
   input  logic [DATA_W*N_CH-1:0]   req_next_i,
   output logic [N_CH-1:0]          rsp_val_o,
   input  logic [N_CH-1:0]          rsp_rdy_i,
   output logic [DATA_W-1:0]        rsp_addr_o,
   output logic [DATA_W-1:0]        rsp_size_o,
   output logic [DATA_W-1:0]        rsp_next_o,
   output logic                     rsp_err_o,
   output logic                     mem_req_val_o,
   input  logic                     mem_req_rdy_i,
   output logic                     mem_req_is_write_o,
   output logic                     mem_req_is_cas_o,
   output logic [DATA_W-1:0]        mem_req_addr_o,
   output logic [DATA_W-1:0]        mem_req_data_o,
   output logic [DATA_W-1:0]        mem_req_cas_exp_o,
   input  logic                     mem_rsp_val_i,
   output logic                     mem_rsp_rdy_o,
   input  logic [DATA_W-1:0]        mem_rsp_data_i
);

   localparam int c_CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

   localparam logic [3:0] c_IDLE     = 4'd0;
   localparam logic [3:0] c_LK_RD    = 4'd1;
   localparam logic [3:0] c_LK_CAS   = 4'd2;
   localparam logic [3:0] c_BACKOFF  = 4'd3;
   localparam logic [3:0] c_UL_WR    = 4'd4;
   localparam logic [3:0] c_LD_SIZE  = 4'd5;
   localparam logic [3:0] c_LD_NEXT  = 4'd6;
   localparam logic [3:0] c_ST_SIZE  = 4'd7;
   localparam logic [3:0] c_ST_NEXT  = 4'd8;
   localparam logic [3:0] c_WAIT_RSP = 4'd9;
   localparam logic [3:0] c_RSP      = 4'd10;

   localparam logic [2:0] c_OP_LOCK   = 3'd0;
   localparam logic [2:0] c_OP_UNLOCK = 3'd1;
   localparam logic [2:0] c_OP_LOAD   = 3'd2;
   localparam logic [2:0] c_OP_INSERT = 3'd3;
   localparam logic [2:0] c_OP_DELETE = 3'd4;

   logic [3:0]        r_state, w_state_nxt, r_issue;
   logic [c_CH_W-1:0] r_rr, r_owner, w_gnt_idx;
   logic              w_gnt_hit, w_take, w_issuing, w_rsp_take, w_fail, w_last_try;
   logic [2:0]        w_sel_op;
   logic [DATA_W-1:0] w_sel_addr, w_sel_size, w_sel_next;
   logic [DATA_W-1:0] r_addr, r_size, r_next, r_ld_size, r_ld_next;
   logic [DATA_W-1:0] w_lock_addr, w_next_addr, w_cas_new, w_fail_dummy;
   logic              r_err;
   logic [31:0]       r_tries, r_bo;
   logic [3:0]        w_fail_nxt;

   // Cyclic search starting just after the last granted channel.
   always_comb begin : p_grant
      int j;
      w_gnt_hit = 1'b0;
      w_gnt_idx = '0;
      j         = 0;
      for (int k = 1; k <= N_CH; k++) begin
         j = int'(r_rr) + k;
         if (j >= N_CH) j = j - N_CH;
         if (!w_gnt_hit && req_val_i[j[c_CH_W-1:0]]) begin
            w_gnt_hit = 1'b1;
            w_gnt_idx = j[c_CH_W-1:0];
         end
      end
   end

   assign w_sel_op    = req_op_i[3*w_gnt_idx +: 3];
   assign w_sel_addr  = req_addr_i[DATA_W*w_gnt_idx +: DATA_W];
   assign w_sel_size  = req_size_i[DATA_W*w_gnt_idx +: DATA_W];
   assign w_sel_next  = req_next_i[DATA_W*w_gnt_idx +: DATA_W];
   assign w_take      = (r_state == c_IDLE) && w_gnt_hit;

   assign w_lock_addr = r_addr + DATA_W'(LOCK_OFFSET);
   assign w_next_addr = r_addr + DATA_W'(NEXT_OFFSET);
   assign w_cas_new   = DATA_W'(r_owner) + DATA_W'(1);
   assign w_fail_dummy = '0;

   assign w_issuing  = (r_state == c_LK_RD)   || (r_state == c_LK_CAS)  ||
                       (r_state == c_UL_WR)   || (r_state == c_LD_SIZE) ||
                       (r_state == c_LD_NEXT) || (r_state == c_ST_SIZE) ||
                       (r_state == c_ST_NEXT);
   assign w_rsp_take = (r_state == c_WAIT_RSP) && mem_rsp_val_i;
   // Lock read sees a held lock, or CAS lost the race: both count as one failed try.
   assign w_fail     = w_rsp_take && ((r_issue == c_LK_RD) || (r_issue == c_LK_CAS)) &&
                       (mem_rsp_data_i != w_fail_dummy);
   assign w_last_try = (r_tries + 32'd1) == 32'(MAX_TRIES);
   assign w_fail_nxt = w_last_try ? c_RSP : ((BACKOFF_CYC == 0) ? c_LK_RD : c_BACKOFF);

   always_ff @(posedge clk_i or posedge rst_i) begin : p_state
      if (rst_i) r_state <= c_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin : p_next
      w_state_nxt = r_state;
      case (r_state)
         c_IDLE: begin
            if (w_gnt_hit) begin
               case (w_sel_op)
                  c_OP_LOCK:   w_state_nxt = c_LK_RD;
                  c_OP_UNLOCK: w_state_nxt = c_UL_WR;
                  c_OP_LOAD:   w_state_nxt = c_LD_SIZE;
                  c_OP_INSERT: w_state_nxt = c_ST_SIZE;
                  c_OP_DELETE: w_state_nxt = c_ST_NEXT;
                  default:     w_state_nxt = c_RSP;
               endcase
            end
         end
         c_LK_RD, c_LK_CAS, c_UL_WR, c_LD_SIZE, c_LD_NEXT, c_ST_SIZE, c_ST_NEXT: begin
            if (mem_req_rdy_i) w_state_nxt = c_WAIT_RSP;
         end
         c_WAIT_RSP: begin
            if (w_fail) w_state_nxt = w_fail_nxt;
            else if (mem_rsp_val_i) begin
               case (r_issue)
                  c_LK_RD:   w_state_nxt = c_LK_CAS;
                  c_LD_SIZE: w_state_nxt = c_LD_NEXT;
                  c_ST_SIZE: w_state_nxt = c_ST_NEXT;
                  default:   w_state_nxt = c_RSP;
               endcase
            end
         end
         c_BACKOFF: begin
            if (r_bo == 32'(BACKOFF_CYC - 1)) w_state_nxt = c_LK_RD;
         end
         c_RSP: begin
            if (rsp_rdy_i[r_owner]) w_state_nxt = c_IDLE;
         end
         default: w_state_nxt = c_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin : p_data
      if (rst_i) begin
         r_rr      <= c_CH_W'(N_CH - 1);
         r_owner   <= '0;
         r_issue   <= c_IDLE;
         r_addr    <= '0;
         r_size    <= '0;
         r_next    <= '0;
         r_ld_size <= '0;
         r_ld_next <= '0;
         r_err     <= 1'b0;
         r_tries   <= '0;
         r_bo      <= '0;
      end else begin
         if (w_take) begin
            r_rr      <= w_gnt_idx;
            r_owner   <= w_gnt_idx;
            r_addr    <= w_sel_addr;
            r_size    <= w_sel_size;
            r_next    <= w_sel_next;
            r_ld_size <= '0;
            r_ld_next <= '0;
            r_err     <= (w_sel_op > c_OP_DELETE);
            r_tries   <= '0;
         end
         if (w_issuing && mem_req_rdy_i) r_issue <= r_state;
         if (w_rsp_take && (r_issue == c_LD_SIZE)) r_ld_size <= mem_rsp_data_i;
         if (w_rsp_take && (r_issue == c_LD_NEXT)) r_ld_next <= mem_rsp_data_i;
         if (w_fail) begin
            r_tries <= r_tries + 32'd1;
            r_bo    <= '0;
            if (w_last_try) r_err <= 1'b1;
         end
         if (r_state == c_BACKOFF) r_bo <= r_bo + 32'd1;
      end
   end

   always_comb begin : p_out
      req_rdy_o          = '0;
      rsp_val_o          = '0;
      rsp_addr_o         = '0;
      rsp_size_o         = '0;
      rsp_next_o         = '0;
      rsp_err_o          = 1'b0;
      mem_req_val_o      = 1'b0;
      mem_req_is_write_o = 1'b0;
      mem_req_is_cas_o   = 1'b0;
      mem_req_addr_o     = '0;
      mem_req_data_o     = '0;
      mem_req_cas_exp_o  = '0;
      mem_rsp_rdy_o      = 1'b0;
      if (w_take) req_rdy_o[w_gnt_idx] = 1'b1;
      case (r_state)
         c_LK_RD: begin
            mem_req_val_o  = 1'b1;
            mem_req_addr_o = w_lock_addr;
         end
         c_LK_CAS: begin
            mem_req_val_o    = 1'b1;
            mem_req_is_cas_o = 1'b1;
            mem_req_addr_o   = w_lock_addr;
            mem_req_data_o   = w_cas_new;
         end
         c_UL_WR: begin
            mem_req_val_o      = 1'b1;
            mem_req_is_write_o = 1'b1;
            mem_req_addr_o     = w_lock_addr;
         end
         c_LD_SIZE: begin
            mem_req_val_o  = 1'b1;
            mem_req_addr_o = r_addr;
         end
         c_LD_NEXT: begin
            mem_req_val_o  = 1'b1;
            mem_req_addr_o = w_next_addr;
         end
         c_ST_SIZE: begin
            mem_req_val_o      = 1'b1;
            mem_req_is_write_o = 1'b1;
            mem_req_addr_o     = r_addr;
            mem_req_data_o     = r_size;
         end
         c_ST_NEXT: begin
            mem_req_val_o      = 1'b1;
            mem_req_is_write_o = 1'b1;
            mem_req_addr_o     = w_next_addr;
            mem_req_data_o     = r_next;
         end
         c_WAIT_RSP: mem_rsp_rdy_o = 1'b1;
         c_RSP: begin
            rsp_val_o[r_owner] = 1'b1;
            rsp_addr_o         = r_addr;
            rsp_size_o         = r_ld_size;
            rsp_next_o         = r_ld_next;
            rsp_err_o          = r_err;
         end
         default: ;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_lsu_mc.sv
`default_nettype none
// ============================================================================
// Module  : tb_lsu_mc
// Brief   : Directed scoreboard bench for lsu_mc (memory slave + core agents).
// Revision: 1.0
// ============================================================================
module tb_lsu_mc;
   localparam int DW = 64;
   localparam int NC = 2;

   logic            clk_i = 1'b0;
   logic            rst_i = 1'b1;
   logic [NC-1:0]   req_val_i, req_rdy_o, rsp_val_o, rsp_rdy_i;
   logic [3*NC-1:0] req_op_i;
   logic [DW*NC-1:0] req_addr_i, req_size_i, req_next_i;
   logic [DW-1:0]   rsp_addr_o, rsp_size_o, rsp_next_o;
   logic            rsp_err_o, mem_req_val_o, mem_req_rdy_i, mem_req_is_write_o, mem_req_is_cas_o;
   logic [DW-1:0]   mem_req_addr_o, mem_req_data_o, mem_req_cas_exp_o, mem_rsp_data_i;
   logic            mem_rsp_val_i, mem_rsp_rdy_o;

   lsu_mc #(.DATA_W(DW), .N_CH(NC), .NEXT_OFFSET(8), .LOCK_OFFSET(16),
            .MAX_TRIES(4), .BACKOFF_CYC(4)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .req_val_i(req_val_i), .req_rdy_o(req_rdy_o), .req_op_i(req_op_i),
      .req_addr_i(req_addr_i), .req_size_i(req_size_i), .req_next_i(req_next_i),
      .rsp_val_o(rsp_val_o), .rsp_rdy_i(rsp_rdy_i), .rsp_addr_o(rsp_addr_o),
      .rsp_size_o(rsp_size_o), .rsp_next_o(rsp_next_o), .rsp_err_o(rsp_err_o),
      .mem_req_val_o(mem_req_val_o), .mem_req_rdy_i(mem_req_rdy_i),
      .mem_req_is_write_o(mem_req_is_write_o), .mem_req_is_cas_o(mem_req_is_cas_o),
      .mem_req_addr_o(mem_req_addr_o), .mem_req_data_o(mem_req_data_o),
      .mem_req_cas_exp_o(mem_req_cas_exp_o), .mem_rsp_val_i(mem_rsp_val_i),
      .mem_rsp_rdy_o(mem_rsp_rdy_o), .mem_rsp_data_i(mem_rsp_data_i)
   );

   always #5 clk_i = ~clk_i;

   typedef struct { bit w; bit cas; logic [DW-1:0] addr; logic [DW-1:0] data; int gap; } mreq_t;
   typedef struct { int ch; logic [DW-1:0] addr; logic [DW-1:0] size; logic [DW-1:0] nxt; bit err; } rsp_t;
   typedef struct { logic [2:0] op; logic [DW-1:0] addr; logic [DW-1:0] size; logic [DW-1:0] nxt; } cmd_t;

   mreq_t         exp_mq[$];
   rsp_t          exp_rq[$];
   logic [DW-1:0] rdq[$];
   cmd_t          cq0[$], cq1[$];
   int            checks = 0, failures = 0;
   int            stall = 0, rsp_hold = 0, stray = 0;
   bit            drop_en = 0;
   logic [DW-1:0] drop_addr = '0;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   function automatic void exp_mem(input bit w, input bit cas, input logic [DW-1:0] a,
                                   input logic [DW-1:0] d, input int gap);
      mreq_t m;
      m.w = w; m.cas = cas; m.addr = a; m.data = d; m.gap = gap;
      exp_mq.push_back(m);
   endfunction

   function automatic void exp_rsp(input int ch, input logic [DW-1:0] a, input logic [DW-1:0] s,
                                   input logic [DW-1:0] n, input bit e);
      rsp_t r;
      r.ch = ch; r.addr = a; r.size = s; r.nxt = n; r.err = e;
      exp_rq.push_back(r);
   endfunction

   function automatic void cmd(input int ch, input logic [2:0] op, input logic [DW-1:0] a,
                               input logic [DW-1:0] s, input logic [DW-1:0] n);
      cmd_t c;
      c.op = op; c.addr = a; c.size = s; c.nxt = n;
      if (ch == 0) cq0.push_back(c);
      else         cq1.push_back(c);
   endfunction

   // Core-side request driver: holds each command until the unit grants it.
   initial begin : p_drv
      req_val_i = '0; req_op_i = '0; req_addr_i = '0; req_size_i = '0; req_next_i = '0;
      forever begin
         @(negedge clk_i);
         req_val_i[0] = (cq0.size() > 0);
         if (cq0.size() > 0) begin
            req_op_i[2:0] = cq0[0].op; req_addr_i[63:0] = cq0[0].addr;
            req_size_i[63:0] = cq0[0].size; req_next_i[63:0] = cq0[0].nxt;
         end
         req_val_i[1] = (cq1.size() > 0);
         if (cq1.size() > 0) begin
            req_op_i[5:3] = cq1[0].op; req_addr_i[127:64] = cq1[0].addr;
            req_size_i[127:64] = cq1[0].size; req_next_i[127:64] = cq1[0].nxt;
         end
         #1;
         if (req_val_i[0] && req_rdy_o[0]) void'(cq0.pop_front());
         if (req_val_i[1] && req_rdy_o[1]) void'(cq1.pop_front());
      end
   end

   // Memory slave and request scoreboard.
   initial begin : p_mem
      int cyc, last_rsp;
      bit pend;
      logic [DW-1:0] pdata;
      mreq_t m;
      cyc = 0; last_rsp = 0; pend = 0; pdata = '0;
      mem_req_rdy_i = 1'b0; mem_rsp_val_i = 1'b0; mem_rsp_data_i = '0;
      forever begin
         @(negedge clk_i);
         cyc++;
         if (pend) begin
            mem_rsp_val_i = 1'b1; mem_rsp_data_i = pdata;
         end else if (stray > 0) begin
            mem_rsp_val_i = 1'b1; mem_rsp_data_i = 64'hBAD; stray--;
         end else begin
            mem_rsp_val_i = 1'b0; mem_rsp_data_i = '0;
         end
         mem_req_rdy_i = (stall == 0);
         #1;
         if (pend && mem_rsp_rdy_o) begin
            pend = 0; last_rsp = cyc;
         end
         if (mem_req_val_o) begin
            if (exp_mq.size() == 0) begin
               checks++; failures++;
               $display("FAIL mem_req_unexpected actual_addr=%h required=none", mem_req_addr_o);
               if (mem_req_rdy_i) begin pend = 1; pdata = '0; end
            end else if (!mem_req_rdy_i) begin
               stall--;
               chk("mem_stall_addr", mem_req_addr_o, exp_mq[0].addr);
               chk("mem_stall_data", mem_req_data_o, exp_mq[0].data);
               chk("mem_stall_wr", DW'(mem_req_is_write_o), DW'(exp_mq[0].w));
            end else begin
               m = exp_mq.pop_front();
               chk("mem_is_write", DW'(mem_req_is_write_o), DW'(m.w));
               chk("mem_is_cas", DW'(mem_req_is_cas_o), DW'(m.cas));
               chk("mem_addr", mem_req_addr_o, m.addr);
               if (m.w || m.cas) chk("mem_data", mem_req_data_o, m.data);
               if (m.cas) chk("mem_cas_exp", mem_req_cas_exp_o, '0);
               if (m.gap > 0) chk("mem_gap", DW'(cyc - last_rsp), DW'(m.gap));
               if (drop_en && m.addr == drop_addr) drop_en = 0;
               else begin
                  pend  = 1;
                  pdata = m.w ? 64'hDEAD : ((rdq.size() > 0) ? rdq.pop_front() : '0);
               end
            end
         end
      end
   end

   // Response monitor: compares every presented response cycle against the queue head.
   initial begin : p_rsp
      rsp_t e;
      logic [NC-1:0] oh;
      rsp_rdy_i = '0;
      forever begin
         @(negedge clk_i);
         #1;
         if (rsp_val_o != '0) begin
            if (exp_rq.size() == 0) begin
               checks++; failures++;
               $display("FAIL rsp_unexpected actual_val=%b required=none", rsp_val_o);
               rsp_rdy_i = '1;
            end else begin
               e = exp_rq[0];
               oh = '0; oh[e.ch] = 1'b1;
               chk("rsp_val", DW'(rsp_val_o), DW'(oh));
               chk("rsp_addr", rsp_addr_o, e.addr);
               chk("rsp_size", rsp_size_o, e.size);
               chk("rsp_next", rsp_next_o, e.nxt);
               chk("rsp_err", DW'(rsp_err_o), DW'(e.err));
               if (rsp_hold > 0) begin
                  rsp_hold--; rsp_rdy_i = ~oh;
               end else begin
                  rsp_rdy_i = '1; void'(exp_rq.pop_front());
               end
            end
         end else rsp_rdy_i = '0;
      end
   end

   task automatic wait_done(input string name, input int budget);
      int n = 0;
      while ((exp_rq.size() != 0 || exp_mq.size() != 0 || cq0.size() != 0 || cq1.size() != 0)
             && n < budget) begin
         @(negedge clk_i); n++;
      end
      checks++;
      if (n >= budget) begin
         failures++;
         $display("FAIL %s_timeout actual_pending_rsp=%0d pending_mem=%0d required=0",
                  name, exp_rq.size(), exp_mq.size());
         exp_rq.delete(); exp_mq.delete(); rdq.delete(); cq0.delete(); cq1.delete();
      end
      repeat (3) @(negedge clk_i);
   endtask

   task automatic chk_quiet(input string name);
      chk({name, "_req_rdy"}, DW'(req_rdy_o), '0);
      chk({name, "_mem_val"}, DW'(mem_req_val_o), '0);
      chk({name, "_mem_rsp_rdy"}, DW'(mem_rsp_rdy_o), '0);
      chk({name, "_rsp_val"}, DW'(rsp_val_o), '0);
      chk({name, "_rsp_err"}, DW'(rsp_err_o), '0);
      chk({name, "_mem_addr"}, mem_req_addr_o, '0);
   endtask

   initial begin : p_main
      int n;
      rst_i = 1'b1;
      repeat (3) @(negedge clk_i);
      #2 chk_quiet("reset");
      @(negedge clk_i);
      rst_i = 1'b0;

      // Two channels valid at reset exit: ch0, ch1, ch0, ch1.
      cmd(0, 3'd2, 64'h1000, 0, 0); cmd(0, 3'd2, 64'h3000, 0, 0);
      cmd(1, 3'd2, 64'h2000, 0, 0); cmd(1, 3'd2, 64'h4000, 0, 0);
      exp_mem(0, 0, 64'h1000, 0, 0); exp_mem(0, 0, 64'h1008, 0, 0);
      exp_mem(0, 0, 64'h2000, 0, 0); exp_mem(0, 0, 64'h2008, 0, 0);
      exp_mem(0, 0, 64'h3000, 0, 0); exp_mem(0, 0, 64'h3008, 0, 0);
      exp_mem(0, 0, 64'h4000, 0, 0); exp_mem(0, 0, 64'h4008, 0, 0);
      rdq.push_back(64'h11); rdq.push_back(64'h12); rdq.push_back(64'h21); rdq.push_back(64'h22);
      rdq.push_back(64'h31); rdq.push_back(64'h32); rdq.push_back(64'h41); rdq.push_back(64'h42);
      exp_rsp(0, 64'h1000, 64'h11, 64'h12, 0); exp_rsp(1, 64'h2000, 64'h21, 64'h22, 0);
      exp_rsp(0, 64'h3000, 64'h31, 64'h32, 0); exp_rsp(1, 64'h4000, 64'h41, 64'h42, 0);
      wait_done("rr_order", 300);

      // Plain LOAD.
      cmd(0, 3'd2, 64'h100, 0, 0);
      exp_mem(0, 0, 64'h100, 0, 0); exp_mem(0, 0, 64'h108, 0, 0);
      rdq.push_back(64'h40); rdq.push_back(64'h200);
      exp_rsp(0, 64'h100, 64'h40, 64'h200, 0);
      wait_done("load", 100);

      // LOCK on ch1: three held reads with backoff, then free, CAS wins.
      cmd(1, 3'd0, 64'h500, 0, 0);
      exp_mem(0, 0, 64'h510, 0, 0); exp_mem(0, 0, 64'h510, 0, 5);
      exp_mem(0, 0, 64'h510, 0, 5); exp_mem(0, 0, 64'h510, 0, 5);
      exp_mem(0, 1, 64'h510, 64'h2, 1);
      rdq.push_back(3); rdq.push_back(3); rdq.push_back(3); rdq.push_back(0); rdq.push_back(0);
      exp_rsp(1, 64'h500, 0, 0, 0);
      wait_done("lock_retry", 200);

      // LOCK exhausts all four tries: no CAS, error response.
      cmd(0, 3'd0, 64'h600, 0, 0);
      exp_mem(0, 0, 64'h610, 0, 0); exp_mem(0, 0, 64'h610, 0, 5);
      exp_mem(0, 0, 64'h610, 0, 5); exp_mem(0, 0, 64'h610, 0, 5);
      rdq.push_back(5); rdq.push_back(5); rdq.push_back(5); rdq.push_back(5);
      exp_rsp(0, 64'h600, 0, 0, 1);
      wait_done("lock_exhaust", 200);

      // Fresh LOCK on ch0 after exhaustion: try count restarts, CAS lost once.
      cmd(0, 3'd0, 64'h600, 0, 0);
      exp_mem(0, 0, 64'h610, 0, 0); exp_mem(0, 1, 64'h610, 64'h1, 1);
      exp_mem(0, 0, 64'h610, 0, 5); exp_mem(0, 1, 64'h610, 64'h1, 1);
      rdq.push_back(0); rdq.push_back(7); rdq.push_back(0); rdq.push_back(0);
      exp_rsp(0, 64'h600, 0, 0, 0);
      wait_done("lock_cas_lost", 200);

      // INSERT with memory stalled 5 cycles and a held-off response.
      stall = 5; rsp_hold = 2;
      cmd(0, 3'd3, 64'h700, 64'h20, 64'h300);
      exp_mem(1, 0, 64'h700, 64'h20, 0); exp_mem(1, 0, 64'h708, 64'h300, 0);
      exp_rsp(0, 64'h700, 0, 0, 0);
      wait_done("insert", 100);

      cmd(1, 3'd1, 64'h800, 0, 0);
      exp_mem(1, 0, 64'h810, 64'h0, 0);
      exp_rsp(1, 64'h800, 0, 0, 0);
      wait_done("unlock", 100);

      cmd(0, 3'd4, 64'h900, 64'h55, 64'hABC);
      exp_mem(1, 0, 64'h908, 64'hABC, 0);
      exp_rsp(0, 64'h900, 0, 0, 0);
      wait_done("delete", 100);

      cmd(1, 3'd7, 64'hA00, 0, 0);
      exp_rsp(1, 64'hA00, 0, 0, 1);
      wait_done("illegal", 100);

      cmd(0, 3'd2, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0);
      exp_mem(0, 0, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0); exp_mem(0, 0, 64'h4, 0, 0);
      rdq.push_back(64'h9); rdq.push_back(64'hA);
      exp_rsp(0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h9, 64'hA, 0);
      wait_done("addr_wrap", 100);

      // Reset while waiting on the LD_NEXT response; that response never arrives.
      drop_en = 1; drop_addr = 64'hB08;
      cmd(0, 3'd2, 64'hB00, 0, 0);
      exp_mem(0, 0, 64'hB00, 0, 0); exp_mem(0, 0, 64'hB08, 0, 0);
      rdq.push_back(64'h77);
      n = 0;
      while (!(exp_mq.size() == 0 && mem_rsp_rdy_o) && n < 100) begin
         @(negedge clk_i); #2; n++;
      end
      chk("rst_wait_reached", DW'(n < 100), DW'(1));
      #1 rst_i = 1'b1;
      #1 chk_quiet("mid_reset");
      @(negedge clk_i); @(negedge clk_i);
      rst_i = 1'b0; stray = 3;
      repeat (4) begin
         @(negedge clk_i); #2;
         chk("post_rst_mem_val", DW'(mem_req_val_o), '0);
         chk("post_rst_rsp_val", DW'(rsp_val_o), '0);
      end
      cmd(1, 3'd2, 64'hD00, 0, 0); cmd(0, 3'd2, 64'hC00, 0, 0);
      exp_mem(0, 0, 64'hC00, 0, 0); exp_mem(0, 0, 64'hC08, 0, 0);
      exp_mem(0, 0, 64'hD00, 0, 0); exp_mem(0, 0, 64'hD08, 0, 0);
      rdq.push_back(64'h5); rdq.push_back(64'h6); rdq.push_back(64'h7); rdq.push_back(64'h8);
      exp_rsp(0, 64'hC00, 64'h5, 64'h6, 0); exp_rsp(1, 64'hD00, 64'h7, 64'h8, 0);
      wait_done("after_reset", 200);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin : p_watchdog
      #500000;
      failures++;
      $display("FAIL watchdog actual=running required=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
